z_seq_monitor: RTL and testbench

Z_SEQ_MONITOR -- requirements
Module: z_seq_monitor

---
 rtl/z_seq_monitor.sv | 135 +++++++++++++
 tb/tb_z_seq_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/z_seq_monitor.sv
// ---------------------------------------------------------------------------
// z_seq_monitor
//
// Purpose:
//   Watches the serial z output of an upstream sequential circuit and detects
//   the bit pattern 1011. Bits are sampled only on cycles where z_valid is
//   high. Each completed pattern produces a registered one-cycle det pulse.
//   A saturating counter tallies the detections.
//
// Configuration macro:
//   Z_SEQ_OVERLAP_EN
//     Defined   : after a match the FSM moves to S1. The trailing 1 can then
//                 start the next pattern, so overlapping matches are seen.
//     Undefined : after a match the FSM returns to IDLE (no overlap).
//
// Parameters:
//   CNT_W    width of the detection counter (legal range 2..16)
//
// Ports:
//   clk      in   single clock, rising-edge active
//   rst_n    in   asynchronous active-low reset
//   z_in     in   serial bit under observation
//   z_valid  in   qualifier; z_in is sampled only when high
//   clr      in   synchronous clear of det_cnt and cnt_sat
//   det      out  one-cycle pulse following the edge that completed 1011
//   det_cnt  out  detections since reset/clr, saturating at 2^CNT_W-1
//   cnt_sat  out  high while det_cnt is at its maximum value
//   state    out  current FSM state (IDLE=0, S1=1, S10=2, S101=3)
// ---------------------------------------------------------------------------
module z_seq_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             z_valid,
    input  logic             clr,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_match;
    logic             r_det;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sat;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Without a valid bit the state simply holds.
    always_comb begin
        w_next_state = r_state;
        w_match      = 1'b0;
        if (z_valid) begin
            case (r_state)
                IDLE: w_next_state = z_in ? S1 : IDLE;
                S1:   w_next_state = z_in ? S1 : S10;
                S10:  w_next_state = z_in ? S101 : IDLE;
                S101: begin
                    if (z_in) begin
                        w_match = 1'b1;
`ifdef Z_SEQ_OVERLAP_EN
                        // The completing 1 doubles as the first bit of the next pattern.
                        w_next_state = S1;
`else
                        w_next_state = IDLE;
`endif
                    end else begin
                        // "10" is still a valid prefix after 1010.
                        w_next_state = S10;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Counter next value: clr wins over a simultaneous match, and the
    // count sticks at its maximum instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (clr) begin
            w_cnt_next = '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Registered detection pulse. This register is independent of clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det <= 1'b0;
        end else begin
            r_det <= w_match;
        end
    end

    // Counter and saturation flag. Both registers update on the same edge,
    // so cnt_sat always agrees with det_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_sat <= (w_cnt_next == CNT_MAX);
        end
    end

    assign det     = r_det;
    assign det_cnt = r_cnt;
    assign cnt_sat = r_sat;
    assign state   = r_state;

endmodule

// File: tb/tb_z_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_z_seq_monitor
//
// Directed testbench for z_seq_monitor. Two instances share all inputs:
//   dutA : default CNT_W = 8
//   dutB : CNT_W = 2, used to reach saturation quickly
// Expected values that depend on Z_SEQ_OVERLAP_EN are selected with the
// same macro.
// ---------------------------------------------------------------------------
module tb_z_seq_monitor;

    logic       clk;
    logic       rst_n;
    logic       z_in;
    logic       z_valid;
    logic       clr;

    logic       detA;
    logic [7:0] cntA;
    logic       satA;
    logic [1:0] stateA;

    logic       detB;
    logic [1:0] cntB;
    logic       satB;
    logic [1:0] stateB;

    int checks;
    int errors;

`ifdef Z_SEQ_OVERLAP_EN
    localparam logic [1:0] AFTER_MATCH = 2'd1;
    localparam logic [7:0] OVERLAP_CNT = 8'd2;
    localparam logic       OVERLAP_DET = 1'b1;
`else
    localparam logic [1:0] AFTER_MATCH = 2'd0;
    localparam logic [7:0] OVERLAP_CNT = 8'd1;
    localparam logic       OVERLAP_DET = 1'b0;
`endif

    z_seq_monitor #(.CNT_W(8)) dutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .z_in    (z_in),
        .z_valid (z_valid),
        .clr     (clr),
        .det     (detA),
        .det_cnt (cntA),
        .cnt_sat (satA),
        .state   (stateA)
    );

    z_seq_monitor #(.CNT_W(2)) dutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .z_in    (z_in),
        .z_valid (z_valid),
        .clr     (clr),
        .det     (detB),
        .det_cnt (cntB),
        .cnt_sat (satB),
        .state   (stateB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs for one rising edge. Outputs are then sampled
    // 1 time unit after that edge.
    task automatic step(input logic v, input logic z, input logic c);
        z_valid = v;
        z_in    = z;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges. This is called 1 unit after an edge.
    task automatic pulseReset();
        z_valid = 1'b0;
        z_in    = 1'b0;
        clr     = 1'b0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        z_valid = 1'b0;
        z_in    = 1'b0;
        clr     = 1'b0;
        #12;
        checks++;
        if (stateA !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", stateA); end
        checks++;
        if (detA !== 1'b0) begin errors++; $display("[TB] FAIL reset_det: got %0b expected 0", detA); end
        checks++;
        if (cntA !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cntA); end
        checks++;
        if (satA !== 1'b0 || satB !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %0b/%0b expected 0/0", satA, satB); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic zSeq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic dExp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, zSeq[i], 1'b0);
            checks++;
            if (detA !== dExp[i]) begin errors++; $display("[TB] FAIL basic_det%0d: got %0b expected %0b", i, detA, dExp[i]); end
        end
        checks++;
        if (cntA !== 8'd1) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected 1", cntA); end
        checks++;
        if (stateA !== AFTER_MATCH) begin errors++; $display("[TB] FAIL basic_state: got %0d expected %0d", stateA, AFTER_MATCH); end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (detA !== 1'b0) begin errors++; $display("[TB] FAIL basic_det_clear: got %0b expected 0", detA); end
        checks++;
        if (stateA !== AFTER_MATCH) begin errors++; $display("[TB] FAIL basic_hold: got %0d expected %0d", stateA, AFTER_MATCH); end
    endtask

    task automatic test_overlap();
        logic zSeq [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        pulseReset();
        for (int i = 0; i < 7; i++) step(1'b1, zSeq[i], 1'b0);
        checks++;
        if (detA !== OVERLAP_DET) begin errors++; $display("[TB] FAIL overlap_det: got %0b expected %0b", detA, OVERLAP_DET); end
        checks++;
        if (cntA !== OVERLAP_CNT) begin errors++; $display("[TB] FAIL overlap_cnt: got %0d expected %0d", cntA, OVERLAP_CNT); end
    endtask

    task automatic test_gaps();
        logic vSeq [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic zSeq [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic dExp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] sExp [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                                 AFTER_MATCH, AFTER_MATCH};
        pulseReset();
        for (int i = 0; i < 9; i++) begin
            step(vSeq[i], zSeq[i], 1'b0);
            checks++;
            if (detA !== dExp[i] || stateA !== sExp[i]) begin
                errors++;
                $display("[TB] FAIL gaps_step%0d: got det=%0b state=%0d expected det=%0b state=%0d",
                         i, detA, stateA, dExp[i], sExp[i]);
            end
        end
        checks++;
        if (cntA !== 8'd1) begin errors++; $display("[TB] FAIL gaps_cnt: got %0d expected 1", cntA); end
    endtask

    task automatic test_saturation();
        logic zSeq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] cExp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       sExp [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int pulses;
        pulses = 0;
        pulseReset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, zSeq[i], 1'b0);
                if (detB === 1'b1) pulses++;
            end
            checks++;
            if (detB !== 1'b1 || cntB !== cExp[p] || satB !== sExp[p]) begin
                errors++;
                $display("[TB] FAIL sat_match%0d: got det=%0b cnt=%0d sat=%0b expected det=1 cnt=%0d sat=%0b",
                         p, detB, cntB, satB, cExp[p], sExp[p]);
            end
        end
        checks++;
        if (pulses != 5) begin errors++; $display("[TB] FAIL sat_pulses: got %0d expected 5", pulses); end
        checks++;
        if (cntA !== 8'd5 || satA !== 1'b0) begin errors++; $display("[TB] FAIL sat_wide_cnt: got cnt=%0d sat=%0b expected cnt=5 sat=0", cntA, satA); end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (cntB !== 2'd0 || satB !== 1'b0) begin errors++; $display("[TB] FAIL sat_clr: got cnt=%0d sat=%0b expected 0/0", cntB, satB); end
    endtask

    task automatic test_clr_collision();
        logic zSeq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        pulseReset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) step(1'b1, zSeq[i], 1'b0);
        checks++;
        if (cntA !== 8'd2) begin errors++; $display("[TB] FAIL clr_pre_cnt: got %0d expected 2", cntA); end
        for (int i = 0; i < 3; i++) step(1'b1, zSeq[i], 1'b0);
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (detA !== 1'b1) begin errors++; $display("[TB] FAIL clr_det: got %0b expected 1", detA); end
        checks++;
        if (cntA !== 8'd0 || satA !== 1'b0) begin errors++; $display("[TB] FAIL clr_cnt: got cnt=%0d sat=%0b expected 0/0", cntA, satA); end
        checks++;
        if (stateA !== AFTER_MATCH) begin errors++; $display("[TB] FAIL clr_state: got %0d expected %0d", stateA, AFTER_MATCH); end
    endtask

    task automatic test_reset_mid();
        logic zSeq [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        pulseReset();
        for (int i = 0; i < 7; i++) step(1'b1, zSeq[i], 1'b0);
        checks++;
        if (stateA !== 2'd3 || cntA !== 8'd1) begin errors++; $display("[TB] FAIL mid_pre: got state=%0d cnt=%0d expected 3/1", stateA, cntA); end
        z_valid = 1'b0;
        rst_n   = 1'b0;
        #2;
        checks++;
        if (stateA !== 2'd0 || detA !== 1'b0 || cntA !== 8'd0 || satA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_in_reset: got state=%0d det=%0b cnt=%0d sat=%0b expected all 0",
                     stateA, detA, cntA, satA);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (stateA !== 2'd1 || detA !== 1'b0) begin errors++; $display("[TB] FAIL mid_resume: got state=%0d det=%0b expected 1/0", stateA, detA); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_saturation();
        test_clr_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
